midi_tx: RTL and testbench



---
 rtl/midi_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_midi_tx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/midi_tx.sv
// MIDI UART transmitter: one status+data message per handshake, 8N1, LSB first, idle-high line.
// Optional running-status compression is enabled with `define MIDI_TX_RUNNING_STATUS_EN.
module midi_tx #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 31250,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       Clk,
  input  logic       Rst_p,
  input  logic       Msg_valid,
  output logic       Msg_ready,
  input  logic [7:0] Msg_status,
  input  logic [7:0] Msg_data1,
  input  logic [7:0] Msg_data2,
  output logic       MIDI_out,
  output logic       Busy,
  output logic       Msg_done,
  output logic       Msg_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_baud, w_baud;
  logic [2:0]       r_bit, w_bit;
  logic [1:0]       r_idx, w_idx;
  logic [1:0]       r_last_idx, w_last_idx;
  logic [7:0]       r_b0, r_b1, r_b2, w_b0, w_b1, w_b2;
  logic             r_out, w_out;
  logic             r_ready, w_ready;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_err, w_err;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0]       r_last_status, w_last_status;
`endif

  logic       w_accept, w_wrap, w_final, w_skip;
  logic [7:0] w_cur, w_d1, w_d2;
  logic [1:0] w_len_idx;

  assign w_accept = Msg_valid & r_ready;
  assign w_wrap   = (r_baud == CNT_W'(CLKS_PER_BIT - 1));
  assign w_final  = (r_idx == r_last_idx);
  assign w_d1     = {1'b0, Msg_data1[6:0]};
  assign w_d2     = {1'b0, Msg_data2[6:0]};

`ifdef MIDI_TX_RUNNING_STATUS_EN
  // Only channel messages (0x80-0xEF) can be compressed.
  assign w_skip = (Msg_status[7:4] != 4'hF) && (Msg_status == r_last_status);
`else
  assign w_skip = 1'b0;
`endif

  // Index of the final byte to send, before any running-status omission.
  always_comb begin
    w_len_idx = 2'd2;
    case (Msg_status[7:4])
      4'hC, 4'hD: w_len_idx = 2'd1;
      4'hF:       w_len_idx = 2'd0;
      default:    w_len_idx = 2'd2;
    endcase
  end

  always_comb begin
    w_cur = r_b2;
    case (r_idx)
      2'd0:    w_cur = r_b0;
      2'd1:    w_cur = r_b1;
      default: w_cur = r_b2;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst_p) begin
    if (Rst_p) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
      r_b2       <= '0;
      r_out      <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      r_last_status <= 8'h00;
`endif
    end else begin
      r_state    <= w_state;
      r_baud     <= w_baud;
      r_bit      <= w_bit;
      r_idx      <= w_idx;
      r_last_idx <= w_last_idx;
      r_b0       <= w_b0;
      r_b1       <= w_b1;
      r_b2       <= w_b2;
      r_out      <= w_out;
      r_ready    <= w_ready;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      r_last_status <= w_last_status;
`endif
    end
  end

  always_comb begin
    w_state    = r_state;
    w_baud     = r_baud;
    w_bit      = r_bit;
    w_idx      = r_idx;
    w_last_idx = r_last_idx;
    w_b0       = r_b0;
    w_b1       = r_b1;
    w_b2       = r_b2;
    w_out      = r_out;
    w_ready    = r_ready;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_err      = 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    w_last_status = r_last_status;
`endif

    case (r_state)
      S_IDLE: begin
        w_baud = '0;
        w_out  = 1'b1;
      end
      S_START: begin
        if (w_wrap) begin
          w_baud  = '0;
          w_bit   = 3'd0;
          w_state = S_DATA;
          w_out   = w_cur[0];
        end else begin
          w_baud = r_baud + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          w_baud = '0;
          if (r_bit == 3'd7) begin
            w_state = S_STOP;
            w_out   = 1'b1;
          end else begin
            w_bit = r_bit + 3'd1;
            w_out = w_cur[r_bit + 3'd1];
          end
        end else begin
          w_baud = r_baud + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (!w_wrap) begin
          w_baud = r_baud + CNT_W'(1);
          // Raise done/ready so they cover the final stop-bit cycle.
          if (w_final && (r_baud == CNT_W'(CLKS_PER_BIT - 2))) begin
            w_done  = 1'b1;
            w_ready = 1'b1;
          end
        end else if (w_final) begin
          w_state = S_IDLE;
          w_baud  = '0;
          w_busy  = 1'b0;
        end else begin
          w_state = S_START;
          w_baud  = '0;
          w_idx   = r_idx + 2'd1;
          w_out   = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Acceptance overrides the idle/completion path so a waiting message starts with no gap.
    if (w_accept) begin
      if (!Msg_status[7]) begin
        w_err = 1'b1;
      end else begin
        if (w_skip) begin
          w_b0       = w_d1;
          w_b1       = w_d2;
          w_b2       = w_d2;
          w_last_idx = w_len_idx - 2'd1;
        end else begin
          w_b0       = Msg_status;
          w_b1       = w_d1;
          w_b2       = w_d2;
          w_last_idx = w_len_idx;
        end
        w_state = S_START;
        w_baud  = '0;
        w_bit   = 3'd0;
        w_idx   = 2'd0;
        w_out   = 1'b0;
        w_ready = 1'b0;
        w_busy  = 1'b1;
`ifdef MIDI_TX_RUNNING_STATUS_EN
        if (Msg_status[7:4] != 4'hF)
          w_last_status = Msg_status;
        else if (!Msg_status[3])
          w_last_status = 8'h00;
`endif
      end
    end
  end

  assign MIDI_out  = r_out;
  assign Msg_ready = r_ready;
  assign Busy      = r_busy;
  assign Msg_done  = r_done;
  assign Msg_err   = r_err;

endmodule

// File: tb/tb_midi_tx.sv
// Directed self-checking bench for midi_tx, run at 16 clocks per bit.
module tb_midi_tx;

  localparam int N = 16;

  logic       Clk, Rst_p, Msg_valid;
  logic       Msg_ready, MIDI_out, Busy, Msg_done, Msg_err;
  logic [7:0] Msg_status, Msg_data1, Msg_data2;

  int n_tests = 0;
  int n_fail  = 0;

  midi_tx #(.CLK_FREQ(500000), .BAUD(31250)) dut (
    .Clk(Clk), .Rst_p(Rst_p), .Msg_valid(Msg_valid), .Msg_ready(Msg_ready),
    .Msg_status(Msg_status), .Msg_data1(Msg_data1), .Msg_data2(Msg_data2),
    .MIDI_out(MIDI_out), .Busy(Busy), .Msg_done(Msg_done), .Msg_err(Msg_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Entered at a negedge; returns at the negedge of the message's final cycle.
  task automatic run_msg(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                         input int nb, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2);
    logic [7:0] exp_b [3];
    logic [9:0] frm [3];
    int total, done_cnt, done_at, busy_low, rdy_early, errs, k, r;
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
    for (int i = 0; i < 3; i++) frm[i] = '0;
    total = 10 * N * nb;
    done_cnt = 0; done_at = -1; busy_low = 0; rdy_early = 0; errs = 0;
    check($sformatf("ready_pre_%02h", st), 32'(Msg_ready), 32'd1);
    Msg_valid = 1'b1; Msg_status = st; Msg_data1 = d1; Msg_data2 = d2;
    @(posedge Clk);
    for (int c = 0; c < total; c++) begin
      @(negedge Clk);
      if (c == 0) begin
        check($sformatf("start_lat_%02h", st), 32'(MIDI_out), 32'd0);
        Msg_valid = 1'b0;
        Msg_status = 8'($urandom); Msg_data1 = 8'($urandom); Msg_data2 = 8'($urandom);
      end
      k = c / (10 * N);
      r = c % (10 * N);
      if (r % N == N / 2) frm[k][r / N] = MIDI_out;
      if (!Busy) busy_low++;
      if (Msg_err) errs++;
      if (Msg_done) begin done_cnt++; done_at = c; end
      if (Msg_ready && c != total - 1) rdy_early++;
    end
    for (int i = 0; i < nb; i++)
      check($sformatf("frame_%02h_b%0d", st, i), 32'(frm[i]), 32'({1'b1, exp_b[i], 1'b0}));
    check($sformatf("done_at_%02h", st), 32'(done_at), 32'(total - 1));
    check($sformatf("done_cnt_%02h", st), 32'(done_cnt), 32'd1);
    check($sformatf("busy_%02h", st), 32'(busy_low), 32'd0);
    check($sformatf("ready_early_%02h", st), 32'(rdy_early), 32'd0);
    check($sformatf("err_%02h", st), 32'(errs), 32'd0);
    check($sformatf("ready_last_%02h", st), 32'(Msg_ready), 32'd1);
  endtask

  initial begin
    int low_cnt;
    Rst_p = 1'b1; Msg_valid = 1'b0;
    Msg_status = 8'h00; Msg_data1 = 8'h00; Msg_data2 = 8'h00;
    idle(3);
    check("rst_out",   32'(MIDI_out),  32'd1);
    check("rst_ready", 32'(Msg_ready), 32'd1);
    check("rst_busy",  32'(Busy),      32'd0);
    check("rst_done",  32'(Msg_done),  32'd0);
    check("rst_err",   32'(Msg_err),   32'd0);
    Rst_p = 1'b0;
    idle(2);

    // Note-on, three bytes
    run_msg(8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64);
    idle(1);
    check("idle_busy", 32'(Busy), 32'd0);
    check("idle_line", 32'(MIDI_out), 32'd1);
    idle(3);

    // Program change: two bytes, data bit 7 cleared, data2 ignored
    run_msg(8'hC5, 8'h8A, 8'h55, 2, 8'hC5, 8'h0A, 8'h00);
    idle(4);

    // Realtime byte then a held note-off, back to back
    run_msg(8'hF8, 8'h12, 8'h34, 1, 8'hF8, 8'h00, 8'h00);
    run_msg(8'h80, 8'h40, 8'h00, 3, 8'h80, 8'h40, 8'h00);
    idle(4);

    // Invalid status: error pulse, nothing sent
    Msg_valid = 1'b1; Msg_status = 8'h3C; Msg_data1 = 8'h11; Msg_data2 = 8'h22;
    @(posedge Clk);
    @(negedge Clk);
    Msg_valid = 1'b0;
    check("inv_err",   32'(Msg_err),   32'd1);
    check("inv_ready", 32'(Msg_ready), 32'd1);
    check("inv_line",  32'(MIDI_out),  32'd1);
    check("inv_busy",  32'(Busy),      32'd0);
    @(negedge Clk);
    check("inv_err_pulse", 32'(Msg_err), 32'd0);
    low_cnt = 0;
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge Clk);
      if (!MIDI_out) low_cnt++;
    end
    check("inv_silent", 32'(low_cnt), 32'd0);

    // Pitch bend with high bits in data: both data bytes masked
    run_msg(8'hE3, 8'hFF, 8'h81, 3, 8'hE3, 8'h7F, 8'h01);
    idle(4);

    // Reset during data bit 4 of the status byte (0x80 has bit 4 low)
    Msg_valid = 1'b1; Msg_status = 8'h80; Msg_data1 = 8'h40; Msg_data2 = 8'h00;
    @(posedge Clk);
    @(negedge Clk);
    Msg_valid = 1'b0;
    idle(5 * N + N / 2 - 1);
    check("mid_line_low", 32'(MIDI_out), 32'd0);
    Rst_p = 1'b1;
    #1;
    check("mid_rst_line", 32'(MIDI_out), 32'd1);
    idle(2);
    Rst_p = 1'b0;
    @(negedge Clk);
    check("mid_rst_ready", 32'(Msg_ready), 32'd1);
    check("mid_rst_busy",  32'(Busy),      32'd0);
    low_cnt = 0;
    for (int c = 0; c < 30 * N; c++) begin
      @(negedge Clk);
      if (!MIDI_out || Busy) low_cnt++;
    end
    check("mid_no_residual", 32'(low_cnt), 32'd0);

    // Repeated channel status, then a system common message
    run_msg(8'h91, 8'h40, 8'h7F, 3, 8'h91, 8'h40, 8'h7F);
    idle(2);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    run_msg(8'h91, 8'h40, 8'h7F, 2, 8'h40, 8'h7F, 8'h00);
`else
    run_msg(8'h91, 8'h40, 8'h7F, 3, 8'h91, 8'h40, 8'h7F);
`endif
    idle(2);
    run_msg(8'hF2, 8'h05, 8'h06, 1, 8'hF2, 8'h00, 8'h00);
    idle(2);
    run_msg(8'h91, 8'h41, 8'h20, 3, 8'h91, 8'h41, 8'h20);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
